// File: rtl/btn_input_ctrl_pkg.sv
// Shared definitions for the push-button conditioning stage.
// Button indices, default timing/width parameters and the debounce state type.
// Both the top level and the character bench import this package.
package btn_input_ctrl_pkg;

  // Bit positions of each button in the btn_* buses.
  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_JUMP  = 2;

  localparam int unsigned DEF_BTN_NUM     = 3;
  // 10 ms at 100 MHz.
  localparam int unsigned DEF_DB_CYCLES   = 1000000;
  localparam int unsigned DEF_HOLD_WIDTH  = 8;
  // Matches the debug sequence display length.
  localparam int unsigned DEF_PRESS_WIDTH = 20;

  typedef enum logic {
    StIdleLo,
    StIdleHi
  } db_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM, edge detect,
// tick-based hold-duration counter and wrapping press counter.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   btn_raw_i       raw asynchronous button pin
//   tick_i          one-cycle character-clock enable (hold timing only)
//   level_o         debounced level
//   posedge_o       one-cycle pulse on an accepted press
//   negedge_o       one-cycle pulse on an accepted release
//   hold_cnt_o      saturating ticks elapsed in the current press
//   release_len_o   hold count captured at the last release
//   press_cnt_o     accepted presses since reset, wrapping
module btn_channel
  import btn_input_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned HOLD_WIDTH  = DEF_HOLD_WIDTH,
  parameter int unsigned PRESS_WIDTH = DEF_PRESS_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   btn_raw_i,
  input  logic                   tick_i,
  output logic                   level_o,
  output logic                   posedge_o,
  output logic                   negedge_o,
  output logic [HOLD_WIDTH-1:0]  hold_cnt_o,
  output logic [HOLD_WIDTH-1:0]  release_len_o,
  output logic [PRESS_WIDTH-1:0] press_cnt_o
);

  localparam int unsigned          CntW    = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0]      CntMax  = CntW'(DB_CYCLES - 1);
  localparam logic [HOLD_WIDTH-1:0] HoldMax = '1;

  logic [1:0]             sync_q;
  db_state_e              state_q;
  logic [CntW-1:0]        db_cnt_q;
  logic                   pos_q, neg_q;
  logic [HOLD_WIDTH-1:0]  hold_q, rel_q;
  logic [PRESS_WIDTH-1:0] press_q;

  logic                  differs, flip, rise, fall;
  logic [HOLD_WIDTH-1:0] hold_inc;

  always_comb begin
    differs  = sync_q[1] != (state_q == StIdleHi);
    flip     = differs && (db_cnt_q == CntMax);
    rise     = flip && (state_q == StIdleLo);
    fall     = flip && (state_q == StIdleHi);
    hold_inc = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      state_q  <= StIdleLo;
      db_cnt_q <= '0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
      hold_q   <= '0;
      rel_q    <= '0;
      press_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw_i};
      // Edge pulses are registered alongside the state flip so they line up with level_o.
      pos_q  <= rise;
      neg_q  <= fall;

      if (!differs) begin
        db_cnt_q <= '0;
      end else if (flip) begin
        db_cnt_q <= '0;
        state_q  <= (state_q == StIdleLo) ? StIdleHi : StIdleLo;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end

      if (rise) begin
        hold_q  <= '0;
        press_q <= press_q + 1'b1;
      end else if (fall) begin
        // A tick landing on the release edge still counts towards the captured length.
        rel_q  <= tick_i ? hold_inc : hold_q;
        hold_q <= '0;
      end else if ((state_q == StIdleHi) && tick_i) begin
        hold_q <= hold_inc;
      end
    end
  end

  assign level_o       = (state_q == StIdleHi);
  assign posedge_o     = pos_q;
  assign negedge_o     = neg_q;
  assign hold_cnt_o    = hold_q;
  assign release_len_o = rel_q;
  assign press_cnt_o   = press_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// Conditions the raw board push-buttons (left, right, jump) for the character
// physics block and the debug counters. One btn_channel per button; outputs
// are packed into flat buses, channel k at [k*W +: W].
// Ports:
//   sys_clk, sys_rst_n  100 MHz clock, asynchronous active-low reset
//   btn_raw             raw button pins
//   tick                character-clock enable
//   btn_level           debounced levels
//   btn_posedge/negedge one-cycle accepted press/release pulses
//   hold_cnt            per-channel ticks in the current press
//   release_len         per-channel hold count at last release
//   press_cnt           per-channel press counters
module btn_input_ctrl
  import btn_input_ctrl_pkg::*;
#(
  parameter int unsigned BTN_NUM     = DEF_BTN_NUM,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned HOLD_WIDTH  = DEF_HOLD_WIDTH,
  parameter int unsigned PRESS_WIDTH = DEF_PRESS_WIDTH
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic [BTN_NUM-1:0]             btn_raw,
  input  logic                           tick,
  output logic [BTN_NUM-1:0]             btn_level,
  output logic [BTN_NUM-1:0]             btn_posedge,
  output logic [BTN_NUM-1:0]             btn_negedge,
  output logic [BTN_NUM*HOLD_WIDTH-1:0]  hold_cnt,
  output logic [BTN_NUM*HOLD_WIDTH-1:0]  release_len,
  output logic [BTN_NUM*PRESS_WIDTH-1:0] press_cnt
);

  for (genvar k = 0; k < BTN_NUM; k++) begin : g_chan
    btn_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_WIDTH (HOLD_WIDTH),
      .PRESS_WIDTH(PRESS_WIDTH)
    ) u_chan (
      .clk_i        (sys_clk),
      .rst_ni       (sys_rst_n),
      .btn_raw_i    (btn_raw[k]),
      .tick_i       (tick),
      .level_o      (btn_level[k]),
      .posedge_o    (btn_posedge[k]),
      .negedge_o    (btn_negedge[k]),
      .hold_cnt_o   (hold_cnt[k*HOLD_WIDTH +: HOLD_WIDTH]),
      .release_len_o(release_len[k*HOLD_WIDTH +: HOLD_WIDTH]),
      .press_cnt_o  (press_cnt[k*PRESS_WIDTH +: PRESS_WIDTH])
    );
  end

endmodule
